srl32_delay_line: RTL and testbench

- 32-deep, 1-bit (per lane) shift register with a dynamically addressable tap output and a fixed last-stage cascade output.
- Functionally equivalent to a Xilinx SRLC32E, plus a synchronous reset.
- Used in the IQ analysis path to delay strobes by a programmable number of cycles; with A=22 the delay is 23 cycles.
- Cascadable: q31 of one instance may feed d of the next.

---
 rtl/srl32_pkg.sv | 14 +
 rtl/srl32_lane.sv | 38 +++
 rtl/srl32_delay_line.sv | 57 +++++
 tb/tb_srl32_delay_line.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/srl32_pkg.sv
// Shared constants and types for the 32-stage SRL delay line.
package srl32_pkg;

  localparam int unsigned SRL_DEPTH  = 32;
  localparam int unsigned SRL_ADDR_W = 5;

  typedef logic [SRL_DEPTH-1:0] srl_word_t;

  // One shift step: the new bit enters stage 0, stage 31 falls off the end.
  function automatic srl_word_t srl_shift(input srl_word_t w, input logic din);
    return {w[SRL_DEPTH-2:0], din};
  endfunction

endpackage

// File: rtl/srl32_lane.sv
// Single 1-bit, 32-stage shift register with an asynchronous tap mux and a
// fixed stage-31 cascade output (SRLC32E-equivalent plus synchronous reset).
module srl32_lane
  import srl32_pkg::*;
#(
  parameter srl_word_t INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  d,
  input  logic [SRL_ADDR_W-1:0] a,
  output logic                  q,
  output logic                  q31
);

  srl_word_t sr_q;
  srl_word_t sr_d;

  always_comb begin
    sr_d = sr_q;
    if (ce) begin
      sr_d = srl_shift(sr_q, d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= INIT;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q   = sr_q[a];
  assign q31 = sr_q[SRL_DEPTH-1];

endmodule

// File: rtl/srl32_delay_line.sv
// LANES parallel 32-stage delay lines sharing clk/rst/ce/a.
// Define SRL_OUTPUT_REG_EN to register q (adds one clock of delay on q only).
module srl32_delay_line
  import srl32_pkg::*;
#(
  parameter logic [31:0] INIT  = 32'h0000_0000,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [LANES-1:0] d,
  input  logic [4:0]       a,
  output logic [LANES-1:0] q,
  output logic [LANES-1:0] q31
);

  logic [LANES-1:0] tap;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    srl32_lane #(
      .INIT (INIT)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .d   (d[l]),
      .a   (a),
      .q   (tap[l]),
      .q31 (q31[l])
    );
  end

`ifdef SRL_OUTPUT_REG_EN
  logic [LANES-1:0] q_r_q;
  logic [LANES-1:0] q_r_d;

  // The output register samples every edge, ignoring ce, so a tap change
  // still shows up one clock later while shifting is stalled.
  always_comb begin
    q_r_d = tap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r_q <= {LANES{INIT[0]}};
    end else begin
      q_r_q <= q_r_d;
    end
  end

  assign q = q_r_q;
`else
  assign q = tap;
`endif

endmodule

// File: tb/tb_srl32_delay_line.sv
// Directed self-checking bench for srl32_delay_line (default and registered-q builds).
module tb_srl32_delay_line;

`ifdef SRL_OUTPUT_REG_EN
  localparam int QLAT = 1;
`else
  localparam int QLAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       m_ce;
  logic [1:0] m_d, m_q, m_q31;
  logic [4:0] m_a;

  logic       r_ce;
  logic [0:0] r_d, r_q, r_q31;
  logic [4:0] r_a;

  logic       c_ce;
  logic [0:0] c_d, c0_q, c0_q31, c1_q, c1_q31;
  logic [4:0] c0_a, c1_a;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] pat = 32'hA5A5_0F0F;

  srl32_delay_line #(.INIT(32'h0000_0000), .LANES(2)) u_main (
    .clk(clk), .rst(rst), .ce(m_ce), .d(m_d), .a(m_a), .q(m_q), .q31(m_q31)
  );

  srl32_delay_line #(.INIT(32'h8000_0001), .LANES(1)) u_rst (
    .clk(clk), .rst(rst), .ce(r_ce), .d(r_d), .a(r_a), .q(r_q), .q31(r_q31)
  );

  srl32_delay_line #(.INIT(32'h0000_0000), .LANES(1)) u_c0 (
    .clk(clk), .rst(rst), .ce(c_ce), .d(c_d), .a(c0_a), .q(c0_q), .q31(c0_q31)
  );

  srl32_delay_line #(.INIT(32'h0000_0000), .LANES(1)) u_c1 (
    .clk(clk), .rst(rst), .ce(c_ce), .d(c0_q31), .a(c1_a), .q(c1_q), .q31(c1_q31)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    m_ce = 1'b0; m_d = '0; m_a = '0;
    r_ce = 1'b0; r_d = '0; r_a = '0;
    c_ce = 1'b0; c_d = '0; c0_a = '0; c1_a = 5'd31;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_m_q",   32'(m_q),   32'h0);
    check("rst_m_q31", 32'(m_q31), 32'h0);
    check("rst_r_q",   32'(r_q),   32'h1);
    check("rst_r_q31", 32'(r_q31), 32'h1);

    // Default delay: a=22, pulse at edge 10
    m_a  = 5'd22;
    m_ce = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      m_d = (e == 10) ? 2'b01 : 2'b00;
      tick();
      check("dly_q",   32'(m_q),   32'(e == 32 + QLAT));
      check("dly_q31", 32'(m_q31), 32'(e == 41));
    end

    // Dynamic tap: lane 0 gets pat, lane 1 its complement
    for (int i = 0; i < 32; i++) begin
      m_d = {~pat[31-i], pat[31-i]};
      tick();
    end
    m_ce = 1'b0;
    m_d  = '0;
    check("tap_q31", 32'(m_q31), 32'({~pat[31], pat[31]}));
    for (int i = 0; i < 32; i++) begin
      m_a = 5'(i);
`ifdef SRL_OUTPUT_REG_EN
      tick();
`else
      #1;
`endif
      check("tap_q", 32'(m_q), 32'({~pat[i], pat[i]}));
    end

    // Clock enable: a=3, pulse at edge 5, ce low for edges 6..9
    do_reset();
    check("ce_rst_q", 32'(m_q), 32'h0);
    m_a = 5'd3;
    for (int e = 1; e <= 16; e++) begin
      m_ce = !(e >= 6 && e <= 9);
      m_d  = (e == 5) ? 2'b01 : 2'b00;
      tick();
      check("ce_q", 32'(m_q), 32'(e == 12 + QLAT));
    end
    m_ce = 1'b0;
    m_d  = '0;

    // Reset mid-operation with ce=1, INIT=8000_0001
    do_reset();
    r_ce = 1'b1;
    r_d  = 1'b1;
    r_a  = 5'd5;
    for (int e = 1; e <= 49; e++) tick();
    check("ones_q31", 32'(r_q31), 32'h1);
    check("ones_q5",  32'(r_q),   32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_d = 1'b0;
    check("mid_rst_q31", 32'(r_q31), 32'h1);
`ifdef SRL_OUTPUT_REG_EN
    check("mid_rst_qr", 32'(r_q), 32'h1);
`else
    r_a = 5'd0;
    #1;
    check("mid_rst_q0", 32'(r_q), 32'h1);
    r_a = 5'd5;
    #1;
    check("mid_rst_q5", 32'(r_q), 32'h0);
`endif
    tick();
    check("resume_q31", 32'(r_q31), 32'h0);
`ifdef SRL_OUTPUT_REG_EN
    check("resume_qr", 32'(r_q), 32'h0);
`else
    r_a = 5'd1;
    #1;
    check("resume_q1", 32'(r_q), 32'h1);
    r_a = 5'd0;
    #1;
    check("resume_q0", 32'(r_q), 32'h0);
`endif
    r_ce = 1'b0;

    // Cascade: pulse at edge 0 reaches second q31 after edge 63
    do_reset();
    c_ce = 1'b1;
    for (int e = 0; e <= 70; e++) begin
      c_d = (e == 0) ? 1'b1 : 1'b0;
      tick();
      check("casc0_q",   32'(c0_q),   32'(e == 0 + QLAT));
      check("casc0_q31", 32'(c0_q31), 32'(e == 31));
      check("casc1_q31", 32'(c1_q31), 32'(e == 63));
      check("casc1_q",   32'(c1_q),   32'(e == 63 + QLAT));
    end
    c_ce = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
